// File: rtl/seg7_scan_n.sv
// N-digit multiplexed 7-segment scanner: prescaler, ghost blanking, dp, blank mask.
// Define SEG7_LZ_SUPPRESS_EN to add leading-zero suppression.
module seg7_scan_n #(
  parameter int DIGITS       = 8,
  parameter int PRESCALE     = 100000,
  parameter int BLANK_CYCLES = 1,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                      clk_fast,
  input  logic                      rst,
  input  logic [4*DIGITS-1:0]       digits_val,
  input  logic [DIGITS-1:0]         dp_in,
  input  logic [DIGITS-1:0]         digit_en,
  output logic [6:0]                seg_pins,
  output logic                      dp,
  output logic [DIGITS-1:0]         anodes,
  output logic [$clog2(DIGITS)-1:0] scan_idx
);

  localparam int SW = $clog2(DIGITS);
  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLNK = CW'(BLANK_CYCLES);
  localparam logic [SW-1:0] LAST_IDX = SW'(DIGITS - 1);
  localparam logic POL = (ACTIVE_LOW != 0);

  if (DIGITS < 2 || DIGITS > 16) begin : g_bad_digits
    $error("seg7_scan_n: DIGITS must be 2..16");
  end
  if (PRESCALE < 2) begin : g_bad_prescale
    $error("seg7_scan_n: PRESCALE must be >= 2");
  end
  if (BLANK_CYCLES < 0 || BLANK_CYCLES >= PRESCALE) begin : g_bad_blank
    $error("seg7_scan_n: BLANK_CYCLES must be 0..PRESCALE-1");
  end

  function automatic logic [6:0] hex7(input logic [3:0] v);
    unique case (v)
      4'h0: hex7 = 7'b0111111;
      4'h1: hex7 = 7'b0000110;
      4'h2: hex7 = 7'b1011011;
      4'h3: hex7 = 7'b1001111;
      4'h4: hex7 = 7'b1100110;
      4'h5: hex7 = 7'b1101101;
      4'h6: hex7 = 7'b1111101;
      4'h7: hex7 = 7'b0000111;
      4'h8: hex7 = 7'b1111111;
      4'h9: hex7 = 7'b1101111;
      4'hA: hex7 = 7'b1110111;
      4'hB: hex7 = 7'b1111100;
      4'hC: hex7 = 7'b0111001;
      4'hD: hex7 = 7'b1011110;
      4'hE: hex7 = 7'b1111001;
      4'hF: hex7 = 7'b1110001;
    endcase
  endfunction

  logic [CW-1:0]     cnt;
  logic [3:0]        nib;
  logic              lit;
  logic              supp;
  logic [DIGITS-1:0] an_n;
  logic [6:0]        seg_n;
  logic              dp_n;

  assign nib = digits_val[{scan_idx, 2'b00} +: 4];
  assign lit = digit_en[scan_idx] && (cnt >= BLNK);

`ifdef SEG7_LZ_SUPPRESS_EN
  logic [DIGITS-1:0] lz;
  logic              run;

  // lz[k] set when nibbles k..top are all zero; digit 0 never suppressed
  always_comb begin
    lz  = '0;
    run = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      run   = run & (digits_val[4*k +: 4] == 4'h0);
      lz[k] = run;
    end
  end

  assign supp = lz[scan_idx];
`else
  assign supp = 1'b0;
`endif

  always_comb begin
    an_n  = '0;
    seg_n = '0;
    dp_n  = 1'b0;
    if (lit && !supp) begin
      an_n[scan_idx] = 1'b1;
      seg_n          = hex7(nib);
      dp_n           = dp_in[scan_idx];
    end
`ifdef SEG7_LZ_SUPPRESS_EN
    else if (lit && dp_in[scan_idx]) begin
      an_n[scan_idx] = 1'b1;
      dp_n           = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk_fast) begin
    if (rst) begin
      cnt      <= '0;
      scan_idx <= '0;
      anodes   <= {DIGITS{POL}};
      seg_pins <= {7{POL}};
      dp       <= POL;
    end else begin
      if (cnt == LAST) begin
        cnt      <= '0;
        scan_idx <= (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      anodes   <= an_n ^ {DIGITS{POL}};
      seg_pins <= seg_n ^ {7{POL}};
      dp       <= dp_n ^ POL;
    end
  end

endmodule

// File: tb/tb_seg7_scan_n.sv
// Directed bench for seg7_scan_n: DIGITS=4, PRESCALE=4, BLANK_CYCLES=1, active-low.
module tb_seg7_scan_n;

  logic        clk_fast = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits_val = 16'h2713;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  digit_en = 4'hF;
  logic [6:0]  seg_pins;
  logic        dp;
  logic [3:0]  anodes;
  logic [1:0]  scan_idx;

  int total = 0;
  int passed = 0;

  seg7_scan_n #(
    .DIGITS(4), .PRESCALE(4), .BLANK_CYCLES(1), .ACTIVE_LOW(1)
  ) dut (
    .clk_fast(clk_fast), .rst(rst), .digits_val(digits_val),
    .dp_in(dp_in), .digit_en(digit_en), .seg_pins(seg_pins),
    .dp(dp), .anodes(anodes), .scan_idx(scan_idx)
  );

  always #5 clk_fast = ~clk_fast;

  // after return, next negedge is sample c=0 (pre-edge cnt=0, slot 0)
  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk_fast);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk_fast);
    total++;
    if (anodes !== 4'b1111) $display("FAIL rst_anodes got %b want 1111", anodes);
    else passed++;
    total++;
    if (seg_pins !== 7'b1111111) $display("FAIL rst_seg got %b want 1111111", seg_pins);
    else passed++;
    total++;
    if (dp !== 1'b1) $display("FAIL rst_dp got %b want 1", dp);
    else passed++;
    total++;
    if (scan_idx !== 2'd0) $display("FAIL rst_idx got %0d want 0", scan_idx);
    else passed++;
  endtask

  task automatic test_scan();
    logic [6:0] segtab [4] = '{7'b0110000, 7'b1111001, 7'b1111000, 7'b0100100};
    logic [3:0] ea;
    logic [6:0] es;
    logic [1:0] ei;
    int slot;
    digits_val = 16'h2713; dp_in = 4'h0; digit_en = 4'hF;
    do_reset();
    for (int c = 0; c < 18; c++) begin
      @(negedge clk_fast);
      slot = (c / 4) % 4;
      ea = (c % 4 == 0) ? 4'b1111 : ~(4'b0001 << slot);
      es = (c % 4 == 0) ? 7'b1111111 : segtab[slot];
      ei = 2'(((c + 1) / 4) % 4);
      total++;
      if (anodes !== ea) $display("FAIL scan_an c=%0d got %b want %b", c, anodes, ea);
      else passed++;
      total++;
      if (seg_pins !== es) $display("FAIL scan_seg c=%0d got %b want %b", c, seg_pins, es);
      else passed++;
      total++;
      if (scan_idx !== ei) $display("FAIL scan_idx c=%0d got %0d want %0d", c, scan_idx, ei);
      else passed++;
      total++;
      if (dp !== 1'b1) $display("FAIL scan_dp c=%0d got %b want 1", c, dp);
      else passed++;
      total++;
      if ($countones(~anodes) > 1) $display("FAIL one_hot c=%0d got %b want <=1 low", c, anodes);
      else passed++;
    end
  endtask

  task automatic test_mask_dp();
    logic [6:0] segtab [4] = '{7'b0110000, 7'b1111001, 7'b1111000, 7'b0100100};
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed;
    logic       on;
    int slot;
    digits_val = 16'h2713; dp_in = 4'b0010; digit_en = 4'b1011;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      @(negedge clk_fast);
      slot = (c / 4) % 4;
      on = (c % 4 != 0) && (slot != 2);
      ea = on ? ~(4'b0001 << slot) : 4'b1111;
      es = on ? segtab[slot] : 7'b1111111;
      ed = (on && slot == 1) ? 1'b0 : 1'b1;
      total++;
      if (anodes !== ea) $display("FAIL mask_an c=%0d got %b want %b", c, anodes, ea);
      else passed++;
      total++;
      if (seg_pins !== es) $display("FAIL mask_seg c=%0d got %b want %b", c, seg_pins, es);
      else passed++;
      total++;
      if (dp !== ed) $display("FAIL mask_dp c=%0d got %b want %b", c, dp, ed);
      else passed++;
    end
  endtask

  task automatic test_mid_slot();
    digits_val = 16'h2713; dp_in = 4'h0; digit_en = 4'hF;
    do_reset();
    @(negedge clk_fast);
    digits_val = 16'h2716;
    @(negedge clk_fast);
    total++;
    if (seg_pins !== 7'b0000010) $display("FAIL mid_seg got %b want 0000010", seg_pins);
    else passed++;
    total++;
    if (anodes !== 4'b1110) $display("FAIL mid_an got %b want 1110", anodes);
    else passed++;
    repeat (8) @(negedge clk_fast);
    total++;
    if (anodes !== 4'b1011) $display("FAIL pre_rst_an got %b want 1011", anodes);
    else passed++;
    total++;
    if (scan_idx !== 2'd2) $display("FAIL pre_rst_idx got %0d want 2", scan_idx);
    else passed++;
    rst = 1'b1;
    @(negedge clk_fast);
    total++;
    if (anodes !== 4'b1111) $display("FAIL mrst_an got %b want 1111", anodes);
    else passed++;
    total++;
    if (seg_pins !== 7'b1111111) $display("FAIL mrst_seg got %b want 1111111", seg_pins);
    else passed++;
    total++;
    if (dp !== 1'b1) $display("FAIL mrst_dp got %b want 1", dp);
    else passed++;
    total++;
    if (scan_idx !== 2'd0) $display("FAIL mrst_idx got %0d want 0", scan_idx);
    else passed++;
    rst = 1'b0;
  endtask

`ifdef SEG7_LZ_SUPPRESS_EN
  task automatic test_lz();
    logic [15:0] vals [3] = '{16'h0042, 16'h0000, 16'h0042};
    logic [3:0]  dps  [3] = '{4'b0000, 4'b0000, 4'b1000};
    logic [3:0]  lit  [3] = '{4'b0011, 4'b0001, 4'b1011};
    logic [6:0]  segs [3][4] = '{
      '{7'b0100100, 7'b0011001, 7'b1111111, 7'b1111111},
      '{7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111},
      '{7'b0100100, 7'b0011001, 7'b1111111, 7'b1111111}};
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed;
    logic       on;
    int slot;
    for (int t = 0; t < 3; t++) begin
      digits_val = vals[t]; dp_in = dps[t]; digit_en = 4'hF;
      do_reset();
      for (int c = 0; c < 16; c++) begin
        @(negedge clk_fast);
        slot = (c / 4) % 4;
        on = (c % 4 != 0) && lit[t][slot];
        ea = on ? ~(4'b0001 << slot) : 4'b1111;
        es = on ? segs[t][slot] : 7'b1111111;
        ed = (on && dps[t][slot]) ? 1'b0 : 1'b1;
        total++;
        if (anodes !== ea) $display("FAIL lz_an t=%0d c=%0d got %b want %b", t, c, anodes, ea);
        else passed++;
        total++;
        if (seg_pins !== es) $display("FAIL lz_seg t=%0d c=%0d got %b want %b", t, c, seg_pins, es);
        else passed++;
        total++;
        if (dp !== ed) $display("FAIL lz_dp t=%0d c=%0d got %b want %b", t, c, dp, ed);
        else passed++;
      end
    end
  endtask
`else
  task automatic test_leading_zero_shown();
    logic [6:0] segtab [4] = '{7'b0100100, 7'b0011001, 7'b1000000, 7'b1000000};
    logic [3:0] ea;
    logic [6:0] es;
    int slot;
    digits_val = 16'h0042; dp_in = 4'h0; digit_en = 4'hF;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      @(negedge clk_fast);
      slot = (c / 4) % 4;
      ea = (c % 4 == 0) ? 4'b1111 : ~(4'b0001 << slot);
      es = (c % 4 == 0) ? 7'b1111111 : segtab[slot];
      total++;
      if (anodes !== ea) $display("FAIL lz0_an c=%0d got %b want %b", c, anodes, ea);
      else passed++;
      total++;
      if (seg_pins !== es) $display("FAIL lz0_seg c=%0d got %b want %b", c, seg_pins, es);
      else passed++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_scan();
    test_mask_dp();
    test_mid_slot();
`ifdef SEG7_LZ_SUPPRESS_EN
    test_lz();
`else
    test_leading_zero_shown();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
